// File: rtl/imm_extend_stage.sv
// Decode-stage immediate extender with a single-entry valid/ready output register.
// Define IMM_LUI_SHIFT_EN to pre-shift LUI immediates; otherwise LUI is zero-extended.
module imm_extend_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] imm_out,
  output logic        zero_ex,
  output logic [1:0]  imm_kind
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stateT;

  localparam logic [1:0] KIND_NONE  = 2'd0;
  localparam logic [1:0] KIND_SIGN  = 2'd1;
  localparam logic [1:0] KIND_ZERO  = 2'd2;
  localparam logic [1:0] KIND_UPPER = 2'd3;

  stateT       state;
  logic        accept;
  logic [5:0]  opcode;
  logic [15:0] imm;
  logic [31:0] immNext;
  logic        zeroExNext;
  logic [1:0]  kindNext;

  assign opcode    = instr[31:26];
  assign imm       = instr[15:0];
  assign out_valid = (state == FULL);
  assign in_ready  = !stall && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && !flush;

  // Branch offsets stay unshifted; the branch adder applies the <<2.
  always_comb begin
    immNext    = {{16{imm[15]}}, imm};
    zeroExNext = 1'b0;
    kindNext   = KIND_SIGN;
    unique case (opcode)
      6'h0C, 6'h0D, 6'h0E: begin
        immNext    = {16'h0, imm};
        zeroExNext = 1'b1;
        kindNext   = KIND_ZERO;
      end
      6'h0F: begin
`ifdef IMM_LUI_SHIFT_EN
        immNext    = {imm, 16'h0};
        zeroExNext = 1'b0;
        kindNext   = KIND_UPPER;
`else
        immNext    = {16'h0, imm};
        zeroExNext = 1'b1;
        kindNext   = KIND_ZERO;
`endif
      end
      6'h00, 6'h02, 6'h03: begin
        immNext    = 32'h0;
        zeroExNext = 1'b0;
        kindNext   = KIND_NONE;
      end
      default: ;
    endcase
  end

  // Data only loads on accept, so it is stale (not cleared) while EMPTY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      imm_out  <= 32'h0;
      zero_ex  <= 1'b0;
      imm_kind <= KIND_NONE;
    end else if (flush) begin
      state <= EMPTY;
    end else if (!stall) begin
      if (accept) begin
        state    <= FULL;
        imm_out  <= immNext;
        zero_ex  <= zeroExNext;
        imm_kind <= kindNext;
      end else if (out_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: vector table, scoreboard queue, stall/flush/reset sequences.
// Expected LUI behaviour follows IMM_LUI_SHIFT_EN the same way the design does.
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid, zero_ex;
  logic [31:0] imm_out;
  logic [1:0]  imm_kind;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] imm;
    logic        zx;
    logic [1:0]  kind;
  } vecT;

  localparam int NVEC = 15;
  vecT tbl [NVEC];
  vecT sbq [$];

  imm_extend_stage dut (
    .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .zero_ex(zero_ex), .imm_kind(imm_kind)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, check in_ready mid-cycle, advance model and DUT, check outputs.
  task automatic cyc(input logic v, input int idx, input logic st, input logic fl,
                     input logic ordy, input logic rs);
    logic expReady, acc;
    reset = rs; in_valid = v; instr = tbl[idx].instr;
    stall = st; flush = fl; out_ready = ordy;
    #4;
    expReady = !st && (sbq.size() == 0 || ordy);
    chk("in_ready", {31'h0, in_ready}, {31'h0, expReady});
    acc = v && expReady && !fl;
    @(posedge clk);
    #1;
    if (rs || fl) begin
      sbq.delete();
    end else if (!st) begin
      if (sbq.size() > 0 && ordy) begin
        $display("consume %s imm=%h", sbq[0].name, sbq[0].imm);
        void'(sbq.pop_front());
      end
      if (acc) begin
        sbq.push_back(tbl[idx]);
        $display("accept  %s instr=%h", tbl[idx].name, tbl[idx].instr);
      end
    end
    chk("out_valid", {31'h0, out_valid}, {31'h0, (sbq.size() > 0)});
    if (sbq.size() > 0) begin
      chk({"imm_out ", sbq[0].name}, imm_out, sbq[0].imm);
      chk({"zero_ex ", sbq[0].name}, {31'h0, zero_ex}, {31'h0, sbq[0].zx});
      chk({"imm_kind ", sbq[0].name}, {30'h0, imm_kind}, {30'h0, sbq[0].kind});
    end
  endtask

  initial begin
    tbl[0]  = '{"ADDI_0002",  32'h2008_0002, 32'h0000_0002, 1'b0, 2'd1};
    tbl[1]  = '{"ADDI_8888",  32'h2109_8888, 32'hFFFF_8888, 1'b0, 2'd1};
    tbl[2]  = '{"ORI_8888",   32'h3429_8888, 32'h0000_8888, 1'b1, 2'd2};
`ifdef IMM_LUI_SHIFT_EN
    tbl[3]  = '{"LUI_1234",   32'h3C01_1234, 32'h1234_0000, 1'b0, 2'd3};
`else
    tbl[3]  = '{"LUI_1234",   32'h3C01_1234, 32'h0000_1234, 1'b1, 2'd2};
`endif
    tbl[4]  = '{"ANDI_00FF",  32'h3042_00FF, 32'h0000_00FF, 1'b1, 2'd2};
    tbl[5]  = '{"XORI_FFFF",  32'h3843_FFFF, 32'h0000_FFFF, 1'b1, 2'd2};
    tbl[6]  = '{"RTYPE",      32'h0143_8020, 32'h0000_0000, 1'b0, 2'd0};
    tbl[7]  = '{"J",          32'h0800_ABCD, 32'h0000_0000, 1'b0, 2'd0};
    tbl[8]  = '{"JAL",        32'h0C00_8001, 32'h0000_0000, 1'b0, 2'd0};
    tbl[9]  = '{"SLTIU_7FFF", 32'h2C85_7FFF, 32'h0000_7FFF, 1'b0, 2'd1};
    tbl[10] = '{"LW_FFFC",    32'h8FA4_FFFC, 32'hFFFF_FFFC, 1'b0, 2'd1};
    tbl[11] = '{"SW_0010",    32'hAFA4_0010, 32'h0000_0010, 1'b0, 2'd1};
    tbl[12] = '{"BEQ_FFFE",   32'h1085_FFFE, 32'hFFFF_FFFE, 1'b0, 2'd1};
    tbl[13] = '{"OP10_8000",  32'h4000_8000, 32'hFFFF_8000, 1'b0, 2'd1};
    tbl[14] = '{"BGEZ_8004",  32'h0481_8004, 32'hFFFF_8004, 1'b0, 2'd1};

    // Reset and its output values.
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("reset imm_out", imm_out, 32'h0);
    chk("reset zero_ex", {31'h0, zero_ex}, 32'h0);
    chk("reset imm_kind", {30'h0, imm_kind}, 32'h0);

    // Back-to-back table sweep at full throughput (no bubbles).
    for (int i = 0; i < NVEC; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Stall holds the entry for 3 cycles despite out_ready and new input.
    cyc(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush with a simultaneous ANDI: both held entry and ANDI vanish.
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush together with stall: flush wins.
    cyc(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset together with stall while FULL.
    cyc(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst+stall imm_out", imm_out, 32'h0);
    chk("rst+stall imm_kind", {30'h0, imm_kind}, 32'h0);
    chk("rst+stall zero_ex", {31'h0, zero_ex}, 32'h0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, NVEC - 1)),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
